// File: rtl/line_feeder_if.sv
// Pixel-in / column-out handshake bundle for the line feeder.
// Carries no logic; only the two handshakes and the frame markers are grouped.
// slave = feeder side, master = source/sink side.
interface line_feeder_if #(
  parameter int DW = 8
);
  logic [DW-1:0]       pix_i;
  logic                v_i;
  logic                ready_o;
  logic [2:0][DW-1:0]  data_o;
  logic                v_o;
  logic                ready_i;
  logic                last_o;
  logic                frame_done_o;

  modport slave (
    input  pix_i, v_i, ready_i,
    output ready_o, data_o, v_o, last_o, frame_done_o
  );

  modport master (
    output pix_i, v_i, ready_i,
    input  ready_o, data_o, v_o, last_o, frame_done_o
  );
endinterface

// File: rtl/line_feeder.sv
// Buffers two image lines and emits one vertical 3-pixel column per pixel (zero-filled at frame edges).
// Latency: 1 cycle from input accept to column valid; first row is absorbed with no output.
// Backpressure: single output register; ready_o = !v_o || ready_i in STREAM, 0 in FLUSH.
module line_feeder #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int DW     = 8
) (
  input  logic         clk_i,
  input  logic         reset_i,
  line_feeder_if.slave bus
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);

  typedef enum logic [1:0] {
    S_PRIME  = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [CW-1:0]      r_in_col;
  logic [RW-1:0]      r_in_row;
  logic [CW-1:0]      r_out_col;

  // lineA holds row ri-2, lineB holds row ri-1 relative to the incoming row
  logic [DW-1:0]      r_line_a [WIDTH];
  logic [DW-1:0]      r_line_b [WIDTH];

  logic               r_v_o;
  logic [2:0][DW-1:0] r_data_o;
  logic               r_last_o;
  logic               r_frame_done;

  logic               w_free;
  logic               w_ready;
  logic               w_accept;
  logic               w_in_col_end;
  logic               w_in_row_end;
  logic               w_out_col_end;
  logic               w_load;
  logic [2:0][DW-1:0] w_load_dat;
  logic               w_load_last;
  logic [DW-1:0]      w_top;

  assign w_free        = !r_v_o || bus.ready_i;
  // Kept independent of v_i so an upstream valid can never loop back into ready.
  assign w_ready       = reset_i && ((r_state == S_PRIME) || ((r_state == S_STREAM) && w_free));
  assign w_accept      = bus.v_i && w_ready;
  assign w_in_col_end  = (r_in_col == COL_LAST);
  assign w_in_row_end  = (r_in_row == ROW_LAST);
  assign w_out_col_end = (r_out_col == COL_LAST);

  // Row 1 has no real row above it; forcing zero also hides a previous frame's lineA.
  assign w_top = (r_in_row == ROW_ONE) ? '0 : r_line_a[r_in_col];

  // State register
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_state <= S_PRIME;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and the column offered to the output register
  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_dat  = '0;
    w_load_last = 1'b0;
    case (r_state)
      S_PRIME: begin
        if (w_accept && w_in_col_end) begin
          w_state_nxt = S_STREAM;
        end
      end
      S_STREAM: begin
        if (w_accept) begin
          w_load        = 1'b1;
          w_load_dat[0] = w_top;
          w_load_dat[1] = r_line_b[r_in_col];
          w_load_dat[2] = bus.pix_i;
          if (w_in_col_end && w_in_row_end) begin
            w_state_nxt = S_FLUSH;
          end
        end
      end
      S_FLUSH: begin
        // Last output row: no row below, so bottom is zero.
        if (w_free) begin
          w_load        = 1'b1;
          w_load_dat[0] = r_line_a[r_out_col];
          w_load_dat[1] = r_line_b[r_out_col];
          w_load_last   = w_out_col_end;
          if (w_out_col_end) begin
            w_state_nxt = S_PRIME;
          end
        end
      end
      default: begin
        w_state_nxt = S_PRIME;
      end
    endcase
  end

  // Input raster counters and flush column counter
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_in_col  <= '0;
      r_in_row  <= '0;
      r_out_col <= '0;
    end else begin
      if (w_accept) begin
        if (w_in_col_end) begin
          r_in_col <= '0;
          r_in_row <= w_in_row_end ? '0 : r_in_row + RW'(1);
        end else begin
          r_in_col <= r_in_col + CW'(1);
        end
      end
      if ((r_state == S_FLUSH) && w_load) begin
        r_out_col <= w_out_col_end ? '0 : r_out_col + CW'(1);
      end
    end
  end

  // Line memories shift down one row on every accepted pixel (no reset needed)
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      if (r_state == S_STREAM) begin
        r_line_a[r_in_col] <= r_line_b[r_in_col];
      end
      r_line_b[r_in_col] <= bus.pix_i;
    end
  end

  // Single-entry output register and end-of-frame pulse
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      r_v_o        <= 1'b0;
      r_data_o     <= '0;
      r_last_o     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= r_v_o && bus.ready_i && r_last_o;
      if (w_load) begin
        r_v_o    <= 1'b1;
        r_data_o <= w_load_dat;
        r_last_o <= w_load_last;
      end else if (bus.ready_i) begin
        r_v_o    <= 1'b0;
        r_last_o <= 1'b0;
      end
    end
  end

  assign bus.ready_o      = w_ready;
  assign bus.v_o          = r_v_o;
  assign bus.data_o       = r_data_o;
  assign bus.last_o       = r_last_o;
  assign bus.frame_done_o = r_frame_done;

endmodule

// File: tb/tb_line_feeder.sv
// Self-checking bench for line_feeder on a 4x3 frame.
// Table-driven reset/prime/mid-frame-reset vectors, then scoreboarded stream runs.
// Expected columns are built directly from the image array, not from the RTL structure.
module tb_line_feeder;

  localparam int W  = 4;
  localparam int H  = 3;
  localparam int DW = 8;

  logic clk;
  logic rst_n;

  line_feeder_if #(.DW(DW)) bus ();

  line_feeder #(.WIDTH(W), .HEIGHT(H), .DW(DW)) dut (
    .clk_i   (clk),
    .reset_i (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [23:0] dat;
    logic        last;
  } exp_t;

  typedef struct {
    logic        rst;
    logic        v;
    logic [7:0]  pix;
    logic        rdy;
    logic        e_v;
    logic        e_rdy;
    logic [23:0] e_dat;
    logic        e_last;
    logic        e_fd;
  } vec_t;

  int         checks   = 0;
  int         failures = 0;
  exp_t       exp_q[$];
  logic [7:0] pix_q[$];
  int         acc_cnt;
  bit         prev_last_xfer;

  function automatic logic [23:0] col3(input logic [7:0] t, input logic [7:0] m, input logic [7:0] b);
    return {b, m, t};
  endfunction

  function automatic vec_t mkv(input logic rst, input logic v, input logic [7:0] pix, input logic rdy,
                               input logic e_v, input logic e_rdy, input logic [23:0] e_dat);
    vec_t x;
    x.rst = rst; x.v = v; x.pix = pix; x.rdy = rdy;
    x.e_v = e_v; x.e_rdy = e_rdy; x.e_dat = e_dat; x.e_last = 1'b0; x.e_fd = 1'b0;
    return x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue one frame's pixels and its expected WIDTH*HEIGHT columns
  task automatic add_frame(input int base, input bit rnd);
    logic [7:0] img [H][W];
    exp_t e;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        img[r][c] = rnd ? 8'($urandom_range(0, 255)) : 8'(base + 16 * r + c);
        pix_q.push_back(img[r][c]);
      end
    end
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        e.dat  = col3((r > 0) ? img[r-1][c] : 8'h00, img[r][c], (r < H - 1) ? img[r+1][c] : 8'h00);
        e.last = (r == H - 1) && (c == W - 1);
        exp_q.push_back(e);
      end
    end
  endtask

  // vmode: 0 always valid, 1 toggle, 2 random; rmode: 0 always ready, 1 random, 2 hold low cycles 6..10
  task automatic run_stream(input int vmode, input int rmode, input int budget,
                            output int nxfer, output int nfd, output int maxz);
    int   cyc = 0;
    int   zrun = 0;
    bit   done = 0;
    bit   drain = 0;
    bit   prev_acc_out = 0;
    bit   prev_hold = 0;
    logic [23:0] prev_dat = '0;
    bit   vv, rr, xfer, acc;
    exp_t e;
    nxfer = 0; nfd = 0; maxz = 0;
    while (!done) begin
      @(posedge clk); #1;
      vv = (pix_q.size() > 0) && ((vmode == 0) || (vmode == 1 && (cyc % 2) == 0) ||
                                  (vmode == 2 && $urandom_range(0, 3) != 0));
      rr = (rmode == 0) || (rmode == 1 && $urandom_range(0, 2) != 0) ||
           (rmode == 2 && !(cyc >= 6 && cyc <= 10));
      bus.v_i     = vv;
      bus.pix_i   = vv ? pix_q[0] : 8'($urandom_range(0, 255));
      bus.ready_i = rr;
      #1;
      chk("frame_done_timing", 32'(bus.frame_done_o), 32'(prev_last_xfer));
      if (prev_acc_out) chk("latency_v_o", 32'(bus.v_o), 32'd1);
      if (prev_hold) begin
        chk("hold_v_o", 32'(bus.v_o), 32'd1);
        chk("hold_data", 32'(bus.data_o), 32'(prev_dat));
      end
      if (rmode == 2 && cyc >= 6 && cyc <= 10) chk("bp_ready_o", 32'(bus.ready_o), 32'd0);
      xfer = bus.v_o && rr;
      acc  = vv && bus.ready_o;
      prev_last_xfer = xfer && bus.last_o;
      if (xfer) begin
        nxfer++;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL extra_column actual=%0h required=none", bus.data_o);
        end else begin
          e = exp_q.pop_front();
          chk("column_data", 32'(bus.data_o), 32'(e.dat));
          chk("column_last", 32'(bus.last_o), 32'(e.last));
        end
      end
      prev_acc_out = 1'b0;
      if (acc) begin
        prev_acc_out = (acc_cnt >= W);
        void'(pix_q.pop_front());
        acc_cnt = (acc_cnt + 1) % (W * H);
      end
      prev_hold = bus.v_o && !rr;
      prev_dat  = bus.data_o;
      zrun = bus.ready_o ? 0 : zrun + 1;
      if (zrun > maxz) maxz = zrun;
      if (bus.frame_done_o) nfd++;
      cyc++;
      if (exp_q.size() == 0 && pix_q.size() == 0) begin
        if (drain) done = 1;
        drain = 1;
      end
      if (!done && cyc >= budget) begin
        checks++; failures++;
        $display("FAIL stream_timeout actual=%0d_columns_left required=0", exp_q.size());
        exp_q.delete(); pix_q.delete();
        done = 1;
      end
    end
  endtask

  initial begin
    vec_t tbl [9];
    int nx, nf, mz;

    // reset, prime row 0, two stream columns, then a one-cycle reset mid-frame
    tbl[0] = mkv(0, 0, 8'd0,  1, 0, 0, 24'h0);
    tbl[1] = mkv(1, 1, 8'd0,  1, 0, 1, 24'h0);
    tbl[2] = mkv(1, 1, 8'd1,  1, 0, 1, 24'h0);
    tbl[3] = mkv(1, 1, 8'd2,  1, 0, 1, 24'h0);
    tbl[4] = mkv(1, 1, 8'd3,  1, 0, 1, 24'h0);
    tbl[5] = mkv(1, 1, 8'd16, 1, 0, 1, 24'h0);
    tbl[6] = mkv(1, 1, 8'd17, 1, 1, 1, col3(8'd0, 8'd0, 8'd16));
    tbl[7] = mkv(0, 1, 8'd18, 1, 1, 0, col3(8'd0, 8'd1, 8'd17));
    tbl[8] = mkv(1, 0, 8'd0,  1, 0, 1, 24'h0);

    rst_n = 1'b0;
    bus.v_i = 1'b0;
    bus.pix_i = '0;
    bus.ready_i = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 9; i++) begin
      @(posedge clk); #1;
      rst_n       = tbl[i].rst;
      bus.v_i     = tbl[i].v;
      bus.pix_i   = tbl[i].pix;
      bus.ready_i = tbl[i].rdy;
      #1;
      chk($sformatf("vec%0d_v_o", i),     32'(bus.v_o),          32'(tbl[i].e_v));
      chk($sformatf("vec%0d_ready_o", i), 32'(bus.ready_o),      32'(tbl[i].e_rdy));
      chk($sformatf("vec%0d_data_o", i),  32'(bus.data_o),       32'(tbl[i].e_dat));
      chk($sformatf("vec%0d_last_o", i),  32'(bus.last_o),       32'(tbl[i].e_last));
      chk($sformatf("vec%0d_fd", i),      32'(bus.frame_done_o), 32'(tbl[i].e_fd));
    end
    bus.v_i = 1'b0;
    acc_cnt = 0;
    prev_last_xfer = 1'b0;

    // fresh frame after mid-frame reset, full flow
    add_frame(0, 0);
    run_stream(0, 0, 2000, nx, nf, mz);
    chk("basic_xfers", 32'(nx), 32'(W * H));
    chk("basic_frame_done", 32'(nf), 32'd1);
    chk("basic_flush_ready_low", 32'(mz), 32'd4);

    // ready_i held low for 5 cycles mid-row
    add_frame(0, 0);
    run_stream(0, 2, 2000, nx, nf, mz);
    chk("bp_xfers", 32'(nx), 32'(W * H));
    chk("bp_frame_done", 32'(nf), 32'd1);

    // input bubbles
    add_frame(0, 0);
    run_stream(1, 0, 2000, nx, nf, mz);
    chk("bubble_xfers", 32'(nx), 32'(W * H));
    chk("bubble_frame_done", 32'(nf), 32'd1);

    // two back-to-back frames, second offset by 100
    add_frame(0, 0);
    add_frame(100, 0);
    run_stream(0, 0, 2000, nx, nf, mz);
    chk("b2b_xfers", 32'(nx), 32'(2 * W * H));
    chk("b2b_frame_done", 32'(nf), 32'd2);
    chk("b2b_flush_ready_low", 32'(mz), 32'd4);

    // random pixels, random valid and ready over many frames
    for (int f = 0; f < 30; f++) add_frame(0, 1);
    run_stream(2, 1, 20000, nx, nf, mz);
    chk("rand_xfers", 32'(nx), 32'(30 * W * H));
    chk("rand_frame_done", 32'(nf), 32'd30);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/line_feeder.md
# line_feeder

Streaming window feeder that sits upstream of the 3x3 convolution unit. It accepts a raster pixel stream, one 8-bit pixel per handshake. It buffers two image lines and emits one 3-pixel vertical column per output handshake (top, middle, bottom rows), producing exactly WIDTH*HEIGHT columns per frame in raster order. Missing rows above the first line and below the last line are zero-filled.

## Interface
- WIDTH, 640: pixels per line
- HEIGHT, 480: lines per frame
- DW, 8: pixel width in bits
- clk_i  in  1  clock; all logic on posedge
- reset_i  in  1  synchronous, active-low reset (reset when 0)
- pix_i  in  DW  input pixel, raster order
- v_i  in  1  pix_i valid
- ready_o  out  1  feeder can accept pix_i; transfer when v_i && ready_o
- data_o  out  [2:0][DW-1:0]  column: [0]=row r-1 (top), [1]=row r, [2]=row r+1 (bottom)
- v_o  out  1  data_o valid
- ready_i  in  1  downstream accepts; transfer when v_o && ready_i
- last_o  out  1  high with the final column (r=HEIGHT-1, c=WIDTH-1) of a frame
- frame_done_o  out  1  one-cycle pulse after the final column transfers

## Operation
- Storage: two line memories, lineA (row ri-2) and lineB (row ri-1), WIDTH x DW each; asynchronous read, write on accept.
- Counters: in_col 0..WIDTH-1, in_row 0..HEIGHT-1 (input side); out_col for FLUSH. in_col wraps to 0 and increments in_row at WIDTH-1.
- States:
  - PRIME (reset state): input row 0. ready_o=1. Accepted pixel goes to lineB[in_col] only; no output. At the end of row 0, go to STREAM.
  - STREAM: input rows 1..HEIGHT-1. Accepted pixel p at column c loads the output register with {top, lineB[c], p}.
    - top = 0 when in_row==1, else lineA[c].
    - Same cycle: lineA[c]<=lineB[c], lineB[c]<=p.
    - At the end of row HEIGHT-1, go to FLUSH.
  - FLUSH: ready_o=0. Emits WIDTH columns {lineA[out_col], lineB[out_col], 0}, one per free output slot. last_o is set on the column with out_col==WIDTH-1. After that column transfers, frame_done_o pulses and the state returns to PRIME with counters cleared.
- Stale line contents from a previous frame are never emitted: top is forced to 0 for row 1, and lineB is fully rewritten in PRIME.
- Output register (single entry):
  - Loaded when a new column is produced and the slot is free (!v_o || ready_i).
  - Held stable while v_o && !ready_i.
  - v_o clears on transfer if no new load occurs in the same cycle.
- ready_o in STREAM = !v_o || ready_i. ready_o is combinational from state, v_o and ready_i, and is never dependent on v_i.
- Simultaneous output transfer and input accept: the register reloads, v_o stays 1, and there is no bubble.
- Output column count per frame = WIDTH*HEIGHT: (HEIGHT-1) rows from STREAM plus 1 row from FLUSH.

## Timing
- Reset (reset_i=0 at a posedge): state=PRIME, all counters=0, v_o=0, data_o=0, last_o=0, frame_done_o=0. ready_o=0 while reset_i=0.
- Line memories are not reset.
- Reset mid-frame or mid-FLUSH abandons the frame. The next accepted pixel is treated as row 0, col 0.
- Latency: an input accepted at edge N gives v_o=1 with the corresponding column after edge N (1 cycle).
- Sustained throughput: 1 column per cycle when v_i=1 and ready_i=1.
- PRIME adds WIDTH input cycles with no output.
- FLUSH takes >= WIDTH cycles.
- frame_done_o is high for exactly the one cycle following the final transfer. PRIME's ready_o may also be high in that cycle.

## Test plan
- Small frame (WIDTH=4, HEIGHT=3), pixel value = 16*r + c, v_i=1, ready_i=1:
  - Columns in order start {0,0,16}, {0,1,17}, ...; row 1 col 2 = {2,18,34}.
  - Final column = {19,35,0} with last_o=1.
  - 12 columns total; frame_done_o pulses once.
- Backpressure: hold ready_i=0 for 5 cycles mid-row.
  - data_o and v_o stay stable, ready_o=0, no pixel lost.
  - On release the sequence resumes exactly, with no duplicates.
- Input bubbles: v_i toggles 1/0 each cycle.
  - Output sequence is identical to the first test; v_o gaps track the input gaps.
- Two back-to-back frames, second frame values = 100+16*r+c.
  - Second frame row 0 tops are all 0 (no first-frame data).
  - FLUSH of frame 1 holds ready_o=0 for 4 cycles.
- Reset mid-frame: after 6 pixels, pulse reset_i=0 for 1 cycle.
  - Next cycle: v_o=0, ready_o=1.
  - A fresh frame then yields correct values from {0,0,16}.
- Full size (640x480), random pixels, random ready_i:
  - Exactly 307200 output transfers.
  - Every column matches the golden model.
  - last_o is seen only on the final transfer.
